// File: rtl/rvfi_reorder.sv
// rvfi_reorder: gathers retirement packets that arrive out of program order
// on several lanes into a slot window, and re-emits them strictly in order,
// one per cycle, starting from tag 0 after reset.
// Optional starvation watchdog: define RVFI_REORDER_WDOG_EN.
module rvfi_reorder #(
  parameter int LANES       = 3,
  parameter int DEPTH       = 16,
  parameter int PKT_W       = 256,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [LANES-1:0]         in_valid,
  input  logic [64*LANES-1:0]      in_order,
  input  logic [PKT_W*LANES-1:0]   in_pkt,
  output logic                     out_valid,
  output logic [63:0]              out_order,
  output logic [PKT_W-1:0]         out_pkt,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     window_err,
  output logic                     dup_err,
  output logic                     wdog_err
);
  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;
  localparam logic [63:0] DEPTH64 = 64'(DEPTH);

  logic [63:0]      head_q, head_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic [PKT_W-1:0] slot_pkt_q [DEPTH];
  logic             out_valid_q;
  logic [63:0]      out_order_q;
  logic [PKT_W-1:0] out_pkt_q;
  logic             window_err_q, dup_err_q;

  logic [LANES-1:0] wr_en;
  logic [IW-1:0]    wr_idx [LANES];
  logic             win_miss, dup_hit, drain;
  logic [IW-1:0]    head_idx;

  // Unsigned distance from head; wraps naturally modulo 2^64.
  function automatic logic in_window(input logic [63:0] tag, input logic [63:0] head);
    logic [63:0] diff;
    diff = tag - head;
    return diff < DEPTH64;
  endfunction

  assign head_idx = head_q[IW-1:0];
  assign drain    = filled_q[head_idx];

  // Lane acceptance: window check, then collision against pre-edge fills and lower lanes
  always_comb begin
    logic [DEPTH-1:0] claimed;
    claimed  = filled_q;
    wr_en    = '0;
    win_miss = 1'b0;
    dup_hit  = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      wr_idx[i] = in_order[64*i +: IW];
      if (in_valid[i]) begin
        if (!in_window(in_order[64*i +: 64], head_q)) begin
          win_miss = 1'b1;
        end else if (claimed[wr_idx[i]]) begin
          dup_hit = 1'b1;
        end else begin
          wr_en[i]           = 1'b1;
          claimed[wr_idx[i]] = 1'b1;
        end
      end
    end
  end

  // Next fill map, head and occupancy; a filled head slot never receives a write
  always_comb begin
    logic [OW-1:0] nwr;
    nwr      = '0;
    filled_d = filled_q;
    head_d   = head_q;
    if (drain) begin
      filled_d[head_idx] = 1'b0;
      head_d             = head_q + 64'd1;
    end
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        filled_d[wr_idx[i]] = 1'b1;
        nwr                 = nwr + OW'(1);
      end
    end
    occ_d = occ_q + nwr - OW'(drain);
  end

  // Payload storage; validity is tracked by filled_q, so no reset needed
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (wr_en[i]) slot_pkt_q[wr_idx[i]] <= in_pkt[PKT_W*i +: PKT_W];
    end
  end

  // Control state, output registers and sticky error flags
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q       <= '0;
      filled_q     <= '0;
      occ_q        <= '0;
      out_valid_q  <= 1'b0;
      out_order_q  <= '0;
      out_pkt_q    <= '0;
      window_err_q <= 1'b0;
      dup_err_q    <= 1'b0;
    end else begin
      head_q       <= head_d;
      filled_q     <= filled_d;
      occ_q        <= occ_d;
      out_valid_q  <= drain;
      window_err_q <= window_err_q | win_miss;
      dup_err_q    <= dup_err_q | dup_hit;
      if (drain) begin
        out_order_q <= head_q;
        out_pkt_q   <= slot_pkt_q[head_idx];
      end
    end
  end

`ifdef RVFI_REORDER_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES + 1);
  logic [CW-1:0] wdog_cnt_q;
  logic          wdog_err_q;

  // Count stalled cycles with buffered data; saturates at the limit
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else if (drain) begin
      wdog_cnt_q <= '0;
    end else if (occ_q != '0 && wdog_cnt_q != CW'(WDOG_CYCLES)) begin
      wdog_cnt_q <= wdog_cnt_q + CW'(1);
      if (wdog_cnt_q + CW'(1) == CW'(WDOG_CYCLES)) wdog_err_q <= 1'b1;
    end
  end

  assign wdog_err = wdog_err_q;
`else
  assign wdog_err = 1'b0;
`endif

  assign out_valid  = out_valid_q;
  assign out_order  = out_order_q;
  assign out_pkt    = out_pkt_q;
  assign occupancy  = occ_q;
  assign window_err = window_err_q;
  assign dup_err    = dup_err_q;
endmodule

// File: tb/tb_rvfi_reorder.sv
// Bench for rvfi_reorder: table-driven ordering vectors, hand sequences for
// window / collision / watchdog / reset, then random traffic against a
// tag-keyed reference model.
module tb_rvfi_reorder;
  localparam int LANES = 3;
  localparam int DEPTH = 16;
  localparam int PKT_W = 32;
  localparam int WD    = 8;
  typedef bit [63:0] tag_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [LANES-1:0]       in_valid;
  logic [64*LANES-1:0]    in_order;
  logic [PKT_W*LANES-1:0] in_pkt;
  logic                   out_valid;
  logic [63:0]            out_order;
  logic [PKT_W-1:0]       out_pkt;
  logic [$clog2(DEPTH):0] occupancy;
  logic                   window_err, dup_err, wdog_err;

  rvfi_reorder #(.LANES(LANES), .DEPTH(DEPTH), .PKT_W(PKT_W), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_order(in_order), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_order(out_order), .out_pkt(out_pkt),
    .occupancy(occupancy), .window_err(window_err), .dup_err(dup_err), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: buffered packets keyed by their order tag
  logic [PKT_W-1:0] m_buf [tag_t];
  tag_t             m_head;
  logic             m_ov;
  tag_t             m_oo;
  logic [PKT_W-1:0] m_op;
  logic             m_werr, m_derr, m_wdog;
  int               m_wcnt;

  tag_t             emitted [$];
  logic [PKT_W-1:0] emitted_pkt [$];

  function automatic void model_edge(input logic r, input logic [2:0] v,
                                     input logic [191:0] ord, input logic [95:0] pk);
    tag_t             t;
    bit               drained, dup;
    int               pre_occ;
    tag_t             acc_t [$];
    logic [PKT_W-1:0] acc_p [$];
    if (r) begin
      m_buf.delete();
      m_head = 0; m_ov = 0; m_oo = 0; m_op = 0;
      m_werr = 0; m_derr = 0; m_wdog = 0; m_wcnt = 0;
      return;
    end
    pre_occ = m_buf.num();
    drained = m_buf.exists(m_head);
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        t = ord[64*i +: 64];
        if (t - m_head >= tag_t'(DEPTH)) m_werr = 1;
        else begin
          dup = m_buf.exists(t);
          foreach (acc_t[k]) if (acc_t[k] == t) dup = 1;
          if (dup) m_derr = 1;
          else begin
            acc_t.push_back(t);
            acc_p.push_back(pk[32*i +: 32]);
          end
        end
      end
    end
`ifdef RVFI_REORDER_WDOG_EN
    if (drained) m_wcnt = 0;
    else if (pre_occ > 0 && m_wcnt < WD) begin
      m_wcnt++;
      if (m_wcnt == WD) m_wdog = 1;
    end
`endif
    if (drained) begin
      m_ov = 1; m_oo = m_head; m_op = m_buf[m_head];
      m_buf.delete(m_head);
      m_head = m_head + 1;
    end else m_ov = 0;
    foreach (acc_t[k]) m_buf[acc_t[k]] = acc_p[k];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, " out_order"}, out_order, m_oo);
    chk({tag, " out_pkt"}, 64'(out_pkt), 64'(m_op));
    chk({tag, " occupancy"}, 64'(occupancy), 64'(m_buf.num()));
    chk({tag, " window_err"}, 64'(window_err), 64'(m_werr));
    chk({tag, " dup_err"}, 64'(dup_err), 64'(m_derr));
    chk({tag, " wdog_err"}, 64'(wdog_err), 64'(m_wdog));
  endtask

  // One clock: drive inputs, take the edge, advance model, sample 1 time unit later
  task automatic step(input logic r, input logic [2:0] v, input tag_t o0, input tag_t o1, input tag_t o2,
                      input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2);
    rst = r; in_valid = v; in_order = {o2, o1, o0}; in_pkt = {p2, p1, p0};
    @(posedge clk);
    model_edge(r, v, {o2, o1, o0}, {p2, p1, p0});
    #1;
    rst = 1'b0; in_valid = '0;
    if (out_valid) begin
      emitted.push_back(out_order);
      emitted_pkt.push_back(out_pkt);
    end
  endtask

  task automatic idle();
    step(0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 3'b000, 0, 0, 0, 0, 0, 0);
    emitted.delete();
    emitted_pkt.delete();
  endtask

  typedef struct {
    logic r; logic [2:0] v; tag_t o0, o1, o2; logic [31:0] p0, p1, p2;
    logic ev; tag_t eo; logic [31:0] ep; int eocc;
  } vec_t;
  vec_t tbl [$];

  function automatic void add(input logic r, input logic [2:0] v, input tag_t o0, input tag_t o1,
                              input tag_t o2, input logic [31:0] p0, input logic [31:0] p1,
                              input logic [31:0] p2, input logic ev, input tag_t eo,
                              input logic [31:0] ep, input int eocc);
    vec_t x;
    x.r = r; x.v = v; x.o0 = o0; x.o1 = o1; x.o2 = o2; x.p0 = p0; x.p1 = p1; x.p2 = p2;
    x.ev = ev; x.eo = eo; x.ep = ep; x.eocc = eocc;
    tbl.push_back(x);
  endfunction

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cnt5;
    rst = 1'b1; in_valid = '0; in_order = '0; in_pkt = '0;

    // Reset state
    do_reset();
    chk("reset out_valid", 64'(out_valid), 0);
    chk("reset out_order", out_order, 0);
    chk("reset out_pkt", 64'(out_pkt), 0);
    chk("reset occupancy", 64'(occupancy), 0);
    chk("reset window_err", 64'(window_err), 0);
    chk("reset dup_err", 64'(dup_err), 0);
    chk("reset wdog_err", 64'(wdog_err), 0);

    // In-order stream on lane 0, then out-of-order fill across lanes
    add(1, 3'b000, 0, 0, 0, 0,      0,      0,      0, 0, 0,      0);
    add(0, 3'b001, 0, 0, 0, 'h100,  0,      0,      0, 0, 0,      1);
    add(0, 3'b001, 1, 0, 0, 'h101,  0,      0,      1, 0, 'h100,  1);
    add(0, 3'b001, 2, 0, 0, 'h102,  0,      0,      1, 1, 'h101,  1);
    add(0, 3'b000, 0, 0, 0, 0,      0,      0,      1, 2, 'h102,  0);
    add(0, 3'b000, 0, 0, 0, 0,      0,      0,      0, 2, 'h102,  0);
    add(1, 3'b000, 0, 0, 0, 0,      0,      0,      0, 0, 0,      0);
    add(0, 3'b110, 0, 1, 2, 0,      'h201,  'h202,  0, 0, 0,      2);
    add(0, 3'b001, 0, 0, 0, 'h200,  0,      0,      0, 0, 0,      3);
    add(0, 3'b000, 0, 0, 0, 0,      0,      0,      1, 0, 'h200,  2);
    add(0, 3'b000, 0, 0, 0, 0,      0,      0,      1, 1, 'h201,  1);
    add(0, 3'b000, 0, 0, 0, 0,      0,      0,      1, 2, 'h202,  0);
    add(0, 3'b000, 0, 0, 0, 0,      0,      0,      0, 2, 'h202,  0);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].o0, tbl[i].o1, tbl[i].o2, tbl[i].p0, tbl[i].p1, tbl[i].p2);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d out_order", i), out_order, tbl[i].eo);
      chk($sformatf("vec%0d out_pkt", i), 64'(out_pkt), 64'(tbl[i].ep));
      chk($sformatf("vec%0d occupancy", i), 64'(occupancy), 64'(tbl[i].eocc));
    end

    // Window: tag 16 with head 0 is dropped
    do_reset();
    step(0, 3'b001, 16, 0, 0, 'hAB, 0, 0);
    chk("window window_err", 64'(window_err), 1);
    chk("window occupancy", 64'(occupancy), 0);
    chk("window dup_err", 64'(dup_err), 0);
    idle();
    chk("window no output", 64'(out_valid), 0);
    step(0, 3'b001, 15, 0, 0, 'hCD, 0, 0);
    chk("window edge accepted", 64'(occupancy), 1);

    // Collision: lanes 0 and 1 both carry tag 5; lane 0 wins
    do_reset();
    step(0, 3'b011, 5, 5, 0, 'hAAAA, 'hBBBB, 0);
    chk("collide dup_err", 64'(dup_err), 1);
    chk("collide occupancy", 64'(occupancy), 1);
    chk("collide window_err", 64'(window_err), 0);
    for (int t = 0; t < 5; t++) step(0, 3'b001, tag_t'(t), 0, 0, 32'h300 + t, 0, 0);
    for (int k = 0; k < 8; k++) idle();
    chk("collide emitted count", 64'(emitted.size()), 6);
    cnt5 = 0;
    foreach (emitted[k]) begin
      chk($sformatf("collide order[%0d]", k), emitted[k], tag_t'(k));
      if (emitted[k] == 5) begin
        cnt5++;
        chk("collide tag5 payload", 64'(emitted_pkt[k]), 'hAAAA);
      end
    end
    chk("collide tag5 once", 64'(cnt5), 1);

    // Watchdog: only tag 1 sent, head starves
    do_reset();
    step(0, 3'b001, 1, 0, 0, 'h11, 0, 0);
    chk("wdog occupancy", 64'(occupancy), 1);
    for (int k = 0; k < 7; k++) idle();
    chk("wdog before limit", 64'(wdog_err), 0);
    idle();
`ifdef RVFI_REORDER_WDOG_EN
    chk("wdog at limit", 64'(wdog_err), 1);
`else
    chk("wdog disabled", 64'(wdog_err), 0);
`endif
    for (int k = 0; k < 4; k++) idle();
    chk("wdog no emission", 64'(emitted.size()), 0);

    // Reset mid-operation drops buffered tags 1 and 2
    do_reset();
    step(0, 3'b110, 0, 1, 2, 0, 'h51, 'h52);
    chk("rst buffered", 64'(occupancy), 2);
    step(1, 3'b001, 0, 0, 0, 'h99, 0, 0);
    chk("rst occupancy", 64'(occupancy), 0);
    chk("rst out_valid", 64'(out_valid), 0);
    step(0, 3'b001, 0, 0, 0, 'h50, 0, 0);
    for (int k = 0; k < 5; k++) idle();
    chk("rst emitted count", 64'(emitted.size()), 1);
    if (emitted.size() > 0) begin
      chk("rst emitted tag", emitted[0], 0);
      chk("rst emitted pkt", 64'(emitted_pkt[0]), 'h50);
    end
    chk("rst final occupancy", 64'(occupancy), 0);

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      logic [2:0]  v;
      tag_t        o [3];
      logic [31:0] p [3];
      v = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        case ($urandom_range(0, 15))
          0:       o[i] = {$urandom, $urandom};
          1, 2:    o[i] = m_head - tag_t'($urandom_range(1, 3));
          3, 4, 5: o[i] = m_head + tag_t'($urandom_range(0, 3));
          default: o[i] = m_head + tag_t'($urandom_range(0, 18));
        endcase
        p[i] = $urandom;
      end
      step(logic'($urandom_range(0, 199) == 0), v, o[0], o[1], o[2], p[0], p[1], p[2]);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rvfi_reorder.md
RVFI_REORDER -- requirements
Module: rvfi_reorder

Interface
REQ-001 SHALL have parameter LANES, default 3, number of independent retirement input lanes.
REQ-002 SHALL have parameter DEPTH, default 16, reorder window slots; power of two, at least 4.
REQ-003 SHALL have parameter PKT_W, default 256, width of the opaque retirement payload per lane.
REQ-004 SHALL have parameter WDOG_CYCLES, default 1024, watchdog limit (used only under RVFI_REORDER_WDOG_EN).
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 in_valid  input  LANES  per-lane retirement strobe.
REQ-008 in_order  input  64*LANES  per-lane program-order tag; lane i occupies bits [64*i+63:64*i].
REQ-009 in_pkt  input  PKT_W*LANES  per-lane payload, packed in the same way as in_order.
REQ-010 out_valid  output  1  one in-order retirement this cycle.
REQ-011 out_order  output  64  order tag of the emitted packet.
REQ-012 out_pkt  output  PKT_W  payload of the emitted packet.
REQ-013 occupancy  output  clog2(DEPTH)+1  number of filled slots.
REQ-014 window_err  output  1  sticky flag: a tag arrived outside the window.
REQ-015 dup_err  output  1  sticky flag: a tag collided with a filled slot.
REQ-016 wdog_err  output  1  sticky flag: the head slot was starved.

Function
REQ-017 SHALL keep a 64-bit head register, which holds the next order tag to emit.
REQ-018 SHALL map each tag to slot index order[clog2(DEPTH)-1:0].
REQ-019 SHALL accept lane i only when head <= in_order_i < head+DEPTH, using the unsigned 64-bit compare of the difference; any other tag SHALL be dropped and SHALL set window_err.
REQ-020 SHALL drop a lane whose target slot is already filled, and SHALL set dup_err.
REQ-021 SHALL resolve two lanes targeting the same slot in one cycle as follows: the lowest lane index is written, every other such lane is dropped, and dup_err is set.
REQ-022 SHALL drain at most one packet per cycle: when the head slot is filled at the start of a cycle, the next edge SHALL move that slot into the output registers, clear the slot, and increment head modulo 2^64.
REQ-023 SHALL drive out_valid high for exactly the one cycle after each drain edge, and low otherwise.
REQ-024 SHALL produce out_valid two cycles after an in_valid whose tag equals head: the write edge, then the drain edge.
REQ-025 SHALL evaluate filled and empty on pre-edge state, so a same-cycle write to slot X and drain from slot Y never conflict; the head slot is always empty when it is written.
REQ-026 SHALL update occupancy as +accepted writes -drain per edge; occupancy SHALL never exceed DEPTH.
REQ-027 SHALL hold out_order and out_pkt stable while out_valid is low.
REQ-028 SHALL never emit a packet with a tag other than the current head; gaps stall emission indefinitely.

Reset
REQ-029 On rst SHALL set head=0, clear all slot-filled bits, and set out_valid=0, out_order=0, out_pkt=0, occupancy=0, window_err=0, dup_err=0, wdog_err=0, and the watchdog counter to 0.
REQ-030 SHALL discard in_valid during a rst cycle; a rst in the middle of operation SHALL drop all buffered packets without emitting them.

Configuration
REQ-031 With RVFI_REORDER_WDOG_EN defined, SHALL count cycles in which occupancy>0 and no drain occurs, SHALL clear the count on each drain, and SHALL set wdog_err when the count reaches WDOG_CYCLES.
REQ-032 Without RVFI_REORDER_WDOG_EN, SHALL contain no watchdog counter, and wdog_err SHALL be constant 0.

Verification
REQ-033 In-order: lane0 sends tags 0,1,2 on consecutive cycles -> out_valid on cycles 2,3,4 with out_order 0,1,2.
REQ-034 Out of order: cycle0 lane2=tag2, lane1=tag1; cycle1 lane0=tag0 -> outputs 0,1,2 on cycles 3,4,5, occupancy peaks at 3.
REQ-035 Window: with head=0 and DEPTH=16, send tag 16 -> window_err=1, packet dropped, occupancy=0.
REQ-036 Collision: lane0 and lane1 both send tag 5 in one cycle -> dup_err=1, only lane0's payload is emitted for tag 5 once tags 0..4 arrive.
REQ-037 Watchdog (macro on, WDOG_CYCLES=8): send tag 1 only -> wdog_err=1 eight cycles after occupancy becomes 1; with the macro off, wdog_err stays 0.
REQ-038 Reset: buffer tags 1,2, then assert rst for one cycle, then send tag 0 -> out_order=0 is emitted, and tags 1 and 2 are never emitted.
